// File: rtl/spi_ram_pkg.sv
// rtl/spi_ram_pkg.sv - shared opcode type and widths for the SPI slave RAM core
package spi_ram_pkg;

    localparam int DATA_W = 8;
    localparam int CMD_W  = 2;

    typedef enum logic [CMD_W-1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } spi_cmd_e;

endpackage

// File: rtl/spi_ram_core.sv
// rtl/spi_ram_core.sv - SPI slave RAM core; define SPI_RAM_AUTOINC_EN for address auto-increment
module spi_ram_core #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_SIZE+1:0] din,
    input  logic                 rx_valid,
    output logic [7:0]           dout,
    output logic                 tx_valid
);
    import spi_ram_pkg::*;

    // Bits needed to index the array; addresses beyond it are caught by the range checks.
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    // Left unreset on purpose so contents survive rst_n and can be preloaded hierarchically.
    logic [DATA_W-1:0]    memory [MEM_DEPTH];

    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;

    spi_cmd_e             cmd;
    logic [ADDR_SIZE-1:0] payload;
    logic [DATA_W-1:0]    data_byte;
    logic                 wr_in_range;
    logic                 rd_in_range;
    logic [DATA_W-1:0]    rd_word;

    assign cmd       = spi_cmd_e'(din[ADDR_SIZE+1:ADDR_SIZE]);
    assign payload   = din[ADDR_SIZE-1:0];
    assign data_byte = din[DATA_W-1:0];

    // Only reachable when MEM_DEPTH is below the full 8-bit address space.
    assign wr_in_range = (int'(wr_addr) < MEM_DEPTH);
    assign rd_in_range = (int'(rd_addr) < MEM_DEPTH);

    // Out-of-range reads still answer, with a zero byte.
    assign rd_word = rd_in_range ? memory[rd_addr[IDX_W-1:0]] : '0;

`ifdef SPI_RAM_AUTOINC_EN
    // Step an address by one, wrapping at the top of the array.
    function automatic logic [ADDR_SIZE-1:0] addr_inc(input logic [ADDR_SIZE-1:0] a);
        if (int'(a) == MEM_DEPTH - 1) begin
            return '0;
        end
        return a + 1'b1;
    endfunction
`endif

    // Command decode: address latches, memory write and read-data return share one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr  <= '0;
            rd_addr  <= '0;
            dout     <= '0;
            tx_valid <= 1'b0;
        end else if (rx_valid) begin
            // Any accepted command other than RD_DATA retires the previous read.
            tx_valid <= 1'b0;
            unique case (cmd)
                CMD_WR_ADDR: begin
                    wr_addr <= payload;
                end
                CMD_WR_DATA: begin
                    if (wr_in_range) begin
                        memory[wr_addr[IDX_W-1:0]] <= data_byte;
                    end
`ifdef SPI_RAM_AUTOINC_EN
                    wr_addr <= addr_inc(wr_addr);
`endif
                end
                CMD_RD_ADDR: begin
                    rd_addr <= payload;
                end
                CMD_RD_DATA: begin
                    dout     <= rd_word;
                    tx_valid <= 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
                    rd_addr  <= addr_inc(rd_addr);
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_ram_core.sv
// tb/tb_spi_ram_core.sv - scoreboard bench for spi_ram_core (honours SPI_RAM_AUTOINC_EN)
module tb_spi_ram_core;
    import spi_ram_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] din = '0;
    logic       rx_valid = 1'b0;
    logic [7:0] dout;
    logic       tx_valid;

    int checks = 0;
    int failures = 0;

    logic [7:0] m_mem [256];
    logic [7:0] m_wa = '0;
    logic [7:0] m_ra = '0;
    logic [7:0] e_dout = '0;
    logic       e_tx = 1'b0;
    logic [7:0] sb_q [$];

    always #5 clk = ~clk;

    spi_ram_core #(
        .MEM_DEPTH(256),
        .ADDR_SIZE(8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (din),
        .rx_valid(rx_valid),
        .dout    (dout),
        .tx_valid(tx_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        dut.memory[a] = d;
        m_mem[a]      = d;
    endtask

    // Called at a negedge; drives one command for one edge and checks outputs at the next negedge.
    task automatic send(input spi_cmd_e op, input logic [7:0] pl);
        logic [7:0] exp_rd;
        din      = {op, pl};
        rx_valid = 1'b1;
        e_tx     = 1'b0;
        case (op)
            CMD_WR_ADDR: m_wa = pl;
            CMD_WR_DATA: begin
                m_mem[m_wa] = pl;
`ifdef SPI_RAM_AUTOINC_EN
                m_wa = m_wa + 8'd1;
`endif
            end
            CMD_RD_ADDR: m_ra = pl;
            CMD_RD_DATA: begin
                sb_q.push_back(m_mem[m_ra]);
                e_tx = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
                m_ra = m_ra + 8'd1;
`endif
            end
        endcase
        @(negedge clk);
        rx_valid = 1'b0;
        if (op == CMD_RD_DATA) begin
            exp_rd = sb_q.pop_front();
            check("rd_dout", {24'd0, dout}, {24'd0, exp_rd});
            e_dout = exp_rd;
        end else begin
            check("hold_dout", {24'd0, dout}, {24'd0, e_dout});
        end
        check("tx_valid", {31'd0, tx_valid}, {31'd0, e_tx});
    endtask

    // Idle cycles with garbage on din; nothing may change.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            din = 10'($urandom);
            @(negedge clk);
            check("idle_dout", {24'd0, dout}, {24'd0, e_dout});
            check("idle_tx", {31'd0, tx_valid}, {31'd0, e_tx});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        preload(8'h02, 8'h33);
        preload(8'h64, 8'hA9);
        preload(8'hAF, 8'h0F);
        preload(8'hFA, 8'hA9);
        #1;
        check("rst_dout", {24'd0, dout}, 32'h0);
        check("rst_tx", {31'd0, tx_valid}, 32'h0);
        check("rst_wr_addr", {24'd0, dut.wr_addr}, 32'h0);
        check("rst_rd_addr", {24'd0, dut.rd_addr}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Preloaded word read through the command path.
        send(CMD_RD_ADDR, 8'h02);
        idle(1);
        send(CMD_RD_DATA, 8'h02);
        check("tp1_dout", {24'd0, dout}, 32'h33);

        // Several preloaded addresses.
        begin
            logic [7:0] addrs [3] = '{8'h64, 8'hAF, 8'hFA};
            logic [7:0] vals  [3] = '{8'hA9, 8'h0F, 8'hA9};
            for (int i = 0; i < 3; i++) begin
                send(CMD_RD_ADDR, addrs[i]);
                send(CMD_RD_DATA, 8'h00);
                check("tp2_dout", {24'd0, dout}, {24'd0, vals[i]});
                check("tp2_tx", {31'd0, tx_valid}, 32'h1);
            end
        end

        // Write then read back with idle gaps.
        send(CMD_WR_ADDR, 8'hAA);
        idle(1);
        send(CMD_WR_DATA, 8'hF0);
        idle(1);
        send(CMD_RD_ADDR, 8'hAA);
        idle(1);
        send(CMD_RD_DATA, 8'h00);
        idle(1);
        check("tp3_dout", {24'd0, dout}, 32'hF0);
        check("tp3_mem", {24'd0, dut.memory[8'hAA]}, 32'hF0);

        // Non-read command retires tx_valid; dout holds; rx_valid=0 freezes state.
        send(CMD_WR_ADDR, 8'h10);
        check("tp4_tx", {31'd0, tx_valid}, 32'h0);
        check("tp4_dout", {24'd0, dout}, 32'hF0);
        idle(3);
        check("tp4_wr_addr", {24'd0, dut.wr_addr}, 32'h10);

        // Read-after-write on consecutive commands.
        send(CMD_WR_ADDR, 8'h30);
        send(CMD_WR_DATA, 8'h5A);
        send(CMD_RD_ADDR, 8'h30);
        send(CMD_RD_DATA, 8'h00);
        check("raw_dout", {24'd0, dout}, 32'h5A);

`ifndef SPI_RAM_AUTOINC_EN
        // Back-to-back reads re-read the same word and keep tx_valid high.
        send(CMD_RD_ADDR, 8'h64);
        send(CMD_RD_DATA, 8'h00);
        send(CMD_RD_DATA, 8'h00);
        check("b2b_dout", {24'd0, dout}, 32'hA9);
        check("b2b_tx", {31'd0, tx_valid}, 32'h1);
        check("b2b_rd_addr", {24'd0, dut.rd_addr}, 32'h64);
`endif

        // Asynchronous reset between edges while a read is presented.
        send(CMD_RD_ADDR, 8'hAA);
        send(CMD_RD_DATA, 8'h00);
        check("pre_rst_tx", {31'd0, tx_valid}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_dout", {24'd0, dout}, 32'h0);
        check("async_rst_tx", {31'd0, tx_valid}, 32'h0);
        e_dout = '0;
        e_tx   = 1'b0;
        m_wa   = '0;
        m_ra   = '0;
        @(negedge clk);
        rst_n = 1'b1;
        send(CMD_RD_ADDR, 8'hAA);
        send(CMD_RD_DATA, 8'h00);
        check("post_rst_dout", {24'd0, dout}, 32'hF0);

`ifdef SPI_RAM_AUTOINC_EN
        // Auto-increment with wrap at the top of the array.
        send(CMD_WR_ADDR, 8'hFF);
        send(CMD_WR_DATA, 8'h11);
        send(CMD_WR_DATA, 8'h22);
        check("ai_mem_ff", {24'd0, dut.memory[8'hFF]}, 32'h11);
        check("ai_mem_00", {24'd0, dut.memory[8'h00]}, 32'h22);
        send(CMD_RD_ADDR, 8'hFF);
        send(CMD_RD_DATA, 8'h00);
        check("ai_rd0", {24'd0, dout}, 32'h11);
        send(CMD_RD_DATA, 8'h00);
        check("ai_rd1", {24'd0, dout}, 32'h22);
        check("ai_rd_addr", {24'd0, dut.rd_addr}, 32'h01);
`endif

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
